// File: rtl/dat_xfer_ctrl.sv
// DAT0/DAT1 transfer sequencer: walks the hp48 bus through LOAD_DP, a run of
// DP_READ/DP_WRITE strobes and LOAD_PC, writing read nibbles back to the register.
module dat_xfer_ctrl #(
   parameter logic [3:0] CMD_NOP      = 4'h0,
   parameter logic [3:0] CMD_LOAD_PC  = 4'h1,
   parameter logic [3:0] CMD_LOAD_DP  = 4'h4,
   parameter logic [3:0] CMD_DP_READ  = 4'h5,
   parameter logic [3:0] CMD_DP_WRITE = 4'h6
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        t_dir,
   input  logic        t_ptr,
   input  logic [3:0]  t_offset,
   input  logic [3:0]  t_cnt,
   input  logic [19:0] d0,
   input  logic [19:0] d1,
   input  logic [19:0] pc,
   input  logic [63:0] reg_in,
   input  logic [3:0]  bus_nibble_out,
   input  logic        bus_error,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic        bus_strobe,
   output logic [3:0]  bus_command,
   output logic [19:0] bus_address,
   output logic [3:0]  bus_nibble_in,
   output logic        wr_en,
   output logic [3:0]  wr_idx,
   output logic [3:0]  wr_nibble
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_LOAD_DP = 3'd1;
   localparam logic [2:0] S_XFER    = 3'd2;
   localparam logic [2:0] S_LOAD_PC = 3'd3;
   localparam logic [2:0] S_DONE    = 3'd4;

   logic [2:0]  state_q, state_d;
   logic [3:0]  k_q, k_d;
   logic        dir_q, dir_d;
   logic [3:0]  offset_q, offset_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [19:0] pc_q, pc_d;
   logic [63:0] data_q, data_d;
   logic        abort_q, abort_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        err_q, err_d;
   logic        bus_strobe_q, bus_strobe_d;
   logic [3:0]  bus_command_q, bus_command_d;
   logic [19:0] bus_address_q, bus_address_d;
   logic [3:0]  bus_nibble_in_q, bus_nibble_in_d;
   logic        wr_en_q, wr_en_d;
   logic [3:0]  wr_idx_q, wr_idx_d;
   logic [3:0]  xfer_idx;

   // Outputs are computed from the state being entered, so they register alongside it.
   always_comb begin
      state_d         = state_q;
      k_d             = k_q;
      dir_d           = dir_q;
      offset_d        = offset_q;
      cnt_d           = cnt_q;
      pc_d            = pc_q;
      data_d          = data_q;
      abort_d         = abort_q;
      err_d           = err_q;
      bus_address_d   = bus_address_q;
      bus_nibble_in_d = bus_nibble_in_q;
      wr_idx_d        = wr_idx_q;
      wr_en_d         = 1'b0;
      busy_d          = 1'b0;
      done_d          = 1'b0;
      bus_strobe_d    = 1'b0;
      bus_command_d   = CMD_NOP;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               dir_d         = t_dir;
               offset_d      = t_offset;
               cnt_d         = t_cnt;
               pc_d          = pc;
               data_d        = reg_in;
               k_d           = 4'd0;
               abort_d       = 1'b0;
               err_d         = 1'b0;
               bus_address_d = t_ptr ? d1 : d0;
               state_d       = S_LOAD_DP;
            end
         end
         S_LOAD_DP: begin
            k_d = 4'd0;
            if (bus_error) begin
               abort_d = 1'b1;
               state_d = S_LOAD_PC;
            end else begin
               state_d = S_XFER;
            end
         end
         S_XFER: begin
            // A fault in this cycle also kills the writeback of this cycle's read.
            if (dir_q && !bus_error) begin
               wr_en_d  = 1'b1;
               wr_idx_d = offset_q + k_q;
            end
            if (bus_error) begin
               abort_d = 1'b1;
               state_d = S_LOAD_PC;
            end else if (k_q == cnt_q) begin
               state_d = S_LOAD_PC;
            end else begin
               k_d = k_q + 4'd1;
            end
         end
         S_LOAD_PC: begin
            err_d   = abort_q | bus_error;
            state_d = S_DONE;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      xfer_idx = offset_d + k_d;
      case (state_d)
         S_LOAD_DP: begin
            busy_d        = 1'b1;
            bus_strobe_d  = 1'b1;
            bus_command_d = CMD_LOAD_DP;
         end
         S_XFER: begin
            busy_d        = 1'b1;
            bus_strobe_d  = 1'b1;
            bus_command_d = dir_d ? CMD_DP_READ : CMD_DP_WRITE;
            if (!dir_d)
               bus_nibble_in_d = data_d[{xfer_idx, 2'b00} +: 4];
         end
         S_LOAD_PC: begin
            busy_d        = 1'b1;
            bus_strobe_d  = 1'b1;
            bus_command_d = CMD_LOAD_PC;
            bus_address_d = pc_d;
         end
         S_DONE:  done_d = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q         <= S_IDLE;
         k_q             <= 4'd0;
         dir_q           <= 1'b0;
         offset_q        <= 4'd0;
         cnt_q           <= 4'd0;
         pc_q            <= 20'd0;
         data_q          <= 64'd0;
         abort_q         <= 1'b0;
         busy_q          <= 1'b0;
         done_q          <= 1'b0;
         err_q           <= 1'b0;
         bus_strobe_q    <= 1'b0;
         bus_command_q   <= CMD_NOP;
         bus_address_q   <= 20'd0;
         bus_nibble_in_q <= 4'd0;
         wr_en_q         <= 1'b0;
         wr_idx_q        <= 4'd0;
      end else begin
         state_q         <= state_d;
         k_q             <= k_d;
         dir_q           <= dir_d;
         offset_q        <= offset_d;
         cnt_q           <= cnt_d;
         pc_q            <= pc_d;
         data_q          <= data_d;
         abort_q         <= abort_d;
         busy_q          <= busy_d;
         done_q          <= done_d;
         err_q           <= err_d;
         bus_strobe_q    <= bus_strobe_d;
         bus_command_q   <= bus_command_d;
         bus_address_q   <= bus_address_d;
         bus_nibble_in_q <= bus_nibble_in_d;
         wr_en_q         <= wr_en_d;
         wr_idx_q        <= wr_idx_d;
      end
   end

   assign busy          = busy_q;
   assign done          = done_q;
   assign err           = err_q;
   assign bus_strobe    = bus_strobe_q;
   assign bus_command   = bus_command_q;
   assign bus_address   = bus_address_q;
   assign bus_nibble_in = bus_nibble_in_q;
   assign wr_en         = wr_en_q;
   assign wr_idx        = wr_idx_q;
   // The read nibble only arrives in the writeback cycle itself, so it is forwarded.
   assign wr_nibble     = wr_en_q ? bus_nibble_out : 4'h0;

endmodule
